// File: rtl/acc_sequencer.sv
// Job sequencer for the shared operand accumulator: clears it, streams operand pairs in over a
// valid/ready handshake, flushes the two-stage path and captures result plus sticky overflow.
module acc_sequencer #(
  parameter int unsigned NB_DATA = 3,
  parameter int unsigned NB_CNT  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [NB_CNT-1:0]    i_len,
  input  logic [1:0]           i_mode,
  input  logic                 i_op_valid,
  input  logic [NB_DATA-1:0]   i_op_a,
  input  logic [NB_DATA-1:0]   i_op_b,
  output logic                 o_op_ready,
  output logic [1:0]           o_sel,
  output logic [NB_DATA-1:0]   o_data1,
  output logic [NB_DATA-1:0]   o_data2,
  output logic                 o_acc_clr_n,
  input  logic [2*NB_DATA-1:0] i_acc_data,
  input  logic                 i_acc_ovf,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*NB_DATA-1:0] o_result,
  output logic                 o_result_ovf
);

  localparam int unsigned NbRes = 2 * NB_DATA;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StFlush,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [NB_CNT-1:0]  len_q, len_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               flush_q, flush_d;
  logic               sticky_q, sticky_d;

  logic               ready_q, ready_d;
  logic [1:0]         sel_q, sel_d;
  logic [NB_DATA-1:0] data1_q, data1_d;
  logic [NB_DATA-1:0] data2_q, data2_d;
  logic               clr_n_q, clr_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NbRes-1:0]   result_q, result_d;
  logic               result_ovf_q, result_ovf_d;

  logic               accept;

  assign accept = (state_q == StRun) && ready_q && i_op_valid;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    flush_d      = flush_q;
    sticky_d     = sticky_q;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    ready_d      = 1'b0;
    // Add-zero by default so the accumulator holds its value.
    sel_d        = 2'b00;
    data1_d      = '0;
    data2_d      = '0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          len_d   = i_len;
          // Select 11 loops the accumulator mux, so mode 11 is folded onto 01 here.
          mode_d  = (i_mode == 2'b11) ? 2'b01 : i_mode;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        sticky_d = 1'b0;
        flush_d  = 1'b0;
        if (len_q == '0) begin
          state_d = StFlush;
        end else begin
          state_d = StRun;
          ready_d = 1'b1;
        end
      end
      StRun: begin
        sticky_d = sticky_q | i_acc_ovf;
        ready_d  = 1'b1;
        if (accept) begin
          sel_d   = mode_q;
          data1_d = i_op_a;
          data2_d = i_op_b;
          cnt_d   = cnt_q + NB_CNT'(1);
          if (cnt_d == len_q) begin
            ready_d = 1'b0;
            flush_d = 1'b0;
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        sticky_d = sticky_q | i_acc_ovf;
        if (flush_q) begin
          state_d      = StDone;
          result_d     = i_acc_data;
          result_ovf_d = sticky_d;
        end else begin
          flush_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    clr_n_d = (state_d != StClear);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      cnt_q        <= '0;
      mode_q       <= 2'b00;
      flush_q      <= 1'b0;
      sticky_q     <= 1'b0;
      ready_q      <= 1'b0;
      sel_q        <= 2'b00;
      data1_q      <= '0;
      data2_q      <= '0;
      clr_n_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      flush_q      <= flush_d;
      sticky_q     <= sticky_d;
      ready_q      <= ready_d;
      sel_q        <= sel_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      clr_n_q      <= clr_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
    end
  end

  assign o_op_ready   = ready_q;
  assign o_sel        = sel_q;
  assign o_data1      = data1_q;
  assign o_data2      = data2_q;
  assign o_acc_clr_n  = clr_n_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_result     = result_q;
  assign o_result_ovf = result_ovf_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a behavioural model of the 3-bit operand accumulator.
module tb_acc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len_i;
  logic [1:0] mode_i;
  logic       op_valid;
  logic [2:0] op_a;
  logic [2:0] op_b;
  logic       op_ready;
  logic [1:0] sel;
  logic [2:0] data1;
  logic [2:0] data2;
  logic       clr_n;
  logic [5:0] acc_data;
  logic       acc_ovf;
  logic       busy;
  logic       done;
  logic [5:0] result;
  logic       result_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int clr_cnt  = 0;
  int sel3_cnt = 0;

  acc_sequencer #(
    .NB_DATA(3),
    .NB_CNT (4)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_len       (len_i),
    .i_mode      (mode_i),
    .i_op_valid  (op_valid),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_op_ready  (op_ready),
    .o_sel       (sel),
    .o_data1     (data1),
    .o_data2     (data2),
    .o_acc_clr_n (clr_n),
    .i_acc_data  (acc_data),
    .i_acc_ovf   (acc_ovf),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (result),
    .o_result_ovf(result_ovf)
  );

  // Accumulator model: 7-bit register, MSB is overflow, adds the selected operand every cycle.
  logic [6:0] acc_q;
  logic [6:0] addend;
  always_comb begin
    addend = '0;
    case (sel)
      2'b00:   addend = {4'b0, data2};
      2'b01:   addend = {4'b0, data1} + {4'b0, data2};
      2'b10:   addend = {4'b0, data1};
      default: addend = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc_q <= '0;
    else if (!clr_n) acc_q <= '0;
    else             acc_q <= acc_q + addend;
  end
  assign acc_data = acc_q[5:0];
  assign acc_ovf  = acc_q[6];

  always @(posedge clk) if (op_valid && op_ready) hs_cnt <= hs_cnt + 1;
  always @(negedge clk) if (!clr_n) clr_cnt <= clr_cnt + 1;
  always @(negedge clk) if (sel == 2'b11) sel3_cnt <= sel3_cnt + 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic start_job(input logic [3:0] len, input logic [1:0] mode);
    @(negedge clk);
    start  = 1'b1;
    len_i  = len;
    mode_i = mode;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Offers one pair, waits for it to be taken, checks the registered operand on the next cycle.
  task automatic send_beat(input logic [2:0] a, input logic [2:0] b, input logic [1:0] exp_sel,
                           input string tag);
    int t;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    t        = 0;
    while (!op_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    op_valid = 1'b0;
    check_eq({tag, " operand"}, {24'd0, sel, data1, data2}, {24'd0, exp_sel, a, b});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int hs0;
    int c0;
    rst_n    = 1'b0;
    start    = 1'b0;
    len_i    = '0;
    mode_i   = '0;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (2) @(negedge clk);
    check_eq("reset outputs", {19'd0, sel, data1, data2, clr_n, op_ready, busy, done},
             {19'd0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check_eq("reset result", {25'd0, result_ovf, result}, 32'd0);
    rst_n = 1'b1;

    // T1: len 3, mode 01, back-to-back pairs -> 3+7+14 = 24
    hs0 = hs_cnt;
    start_job(4'd3, 2'b01);
    check_eq("T1 clear pulse", {30'd0, busy, clr_n}, {30'd0, 1'b1, 1'b0});
    send_beat(3'd1, 3'd2, 2'b01, "T1 b0");
    send_beat(3'd3, 3'd4, 2'b01, "T1 b1");
    send_beat(3'd7, 3'd7, 2'b01, "T1 b2");
    check_eq("T1 ready low", op_ready, 0);
    wait_done(n);
    check_eq("T1 latency", n, 2);
    check_eq("T1 result", {25'd0, result_ovf, result}, {25'd0, 1'b0, 6'd24});
    check_eq("T1 busy in done", busy, 1);
    @(negedge clk);
    check_eq("T1 idle after", {30'd0, busy, done}, 32'd0);
    check_eq("T1 handshakes", hs_cnt - hs0, 3);

    // T2: len 4, mode 00, B=5 with 2-cycle gaps; valid held after the last beat
    hs0 = hs_cnt;
    start_job(4'd4, 2'b00);
    for (int i = 0; i < 4; i++) begin
      send_beat(3'd3, 3'd5, 2'b00, "T2 beat");
      if (i < 3) begin
        repeat (2) begin
          @(negedge clk);
          check_eq("T2 gap add-zero", {27'd0, sel, data2}, 32'd0);
        end
      end
    end
    check_eq("T2 ready low", op_ready, 0);
    op_valid = 1'b1;
    wait_done(n);
    op_valid = 1'b0;
    check_eq("T2 latency", n, 2);
    check_eq("T2 result", {25'd0, result_ovf, result}, {25'd0, 1'b0, 6'd20});
    check_eq("T2 handshakes", hs_cnt - hs0, 4);

    // T3: len 5, mode 01, all (7,7) -> 70 wraps to 6 with overflow
    start_job(4'd5, 2'b01);
    for (int i = 0; i < 5; i++) send_beat(3'd7, 3'd7, 2'b01, "T3 beat");
    wait_done(n);
    check_eq("T3 result", {25'd0, result_ovf, result}, {25'd0, 1'b1, 6'd6});

    // T5: len 0, valid held high, start pulsed during the flush and in the DONE cycle
    hs0      = hs_cnt;
    c0       = clr_cnt;
    op_valid = 1'b1;
    op_a     = 3'd5;
    op_b     = 3'd5;
    start_job(4'd0, 2'b01);
    check_eq("T5 clear low", clr_n, 0);
    @(negedge clk);
    start = 1'b1;
    check_eq("T5 no done flush1", done, 0);
    @(negedge clk);
    start = 1'b0;
    check_eq("T5 no done flush2", done, 0);
    @(negedge clk);
    check_eq("T5 done", done, 1);
    check_eq("T5 result", {25'd0, result_ovf, result}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("T5 start in done ignored", busy, 0);
    @(negedge clk);
    op_valid = 1'b0;
    check_eq("T5 still idle", busy, 0);
    check_eq("T5 clear cycles", clr_cnt - c0, 1);
    check_eq("T5 handshakes", hs_cnt - hs0, 0);

    // T4: mode 11 coerced to 01 -> 5 + 2 = 7
    start_job(4'd2, 2'b11);
    send_beat(3'd2, 3'd3, 2'b01, "T4 b0");
    send_beat(3'd1, 3'd1, 2'b01, "T4 b1");
    wait_done(n);
    check_eq("T4 result", {25'd0, result_ovf, result}, {25'd0, 1'b0, 6'd7});

    // T6: asynchronous reset after 2 of 3 beats, then a fresh mode 10 job
    start_job(4'd3, 2'b01);
    send_beat(3'd3, 3'd4, 2'b01, "T6 b0");
    send_beat(3'd5, 3'd6, 2'b01, "T6 b1");
    #2 rst_n = 1'b0;
    #1;
    check_eq("T6 async reset outputs", {19'd0, sel, data1, data2, clr_n, op_ready, busy, done},
             {19'd0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check_eq("T6 result cleared", {25'd0, result_ovf, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("T6 idle after reset", busy, 0);
    start_job(4'd1, 2'b10);
    send_beat(3'd6, 3'd5, 2'b10, "T6 fresh");
    wait_done(n);
    check_eq("T6 latency", n, 2);
    check_eq("T6 result", {25'd0, result_ovf, result}, {25'd0, 1'b0, 6'd6});

    check_eq("sel 11 never seen", sel3_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
